versioned_store: RTL and testbench

Clocked multi-version data store with parametrised slot count and widths. Holds up to NUM_SLOTS (version, data) pairs written through a valid/ready port. Answers read requests with the newest stored entry whose version is strictly below the requested version. It supersedes the combinational 4-input priority router in the versioned-memory path, adding slot allocation, oldest-version eviction, flush, backpressure and a defined result when versions tie or no entry qualifies.

---
 rtl/versioned_store_pkg.sv | 23 ++
 rtl/version_select.sv | 39 +++
 rtl/versioned_store.sv | 157 +++++++++++++++
 tb/tb_versioned_store.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/versioned_store_pkg.sv
// Shared definitions for the versioned store: default sizing and the selector mode.
`ifndef VERSIONED_STORE_PKG_SV
`define VERSIONED_STORE_PKG_SV

package versioned_store_pkg;

    localparam int unsigned DEFAULT_NUM_SLOTS = 4;
    localparam int unsigned DEFAULT_VERSION_W = 4;
    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned OCC_W             = $clog2(DEFAULT_NUM_SLOTS + 1);

    typedef enum logic {
        SelBelowMax,
        SelGlobalMin
    } sel_mode_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/version_select.sv
// Combinational slot picker: largest version below a bound, or smallest version overall.
// Strict comparisons keep the lowest index on ties.
module version_select
    import versioned_store_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int unsigned VERSION_W = DEFAULT_VERSION_W,
    localparam int unsigned IDX_W    = idx_width(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0]                valid,
    input  logic [NUM_SLOTS-1:0][VERSION_W-1:0] versions,
    input  logic [VERSION_W-1:0]                bound,
    input  sel_mode_e                           mode,
    output logic                                found,
    output logic [IDX_W-1:0]                    index
);

    logic [VERSION_W-1:0] best;
    logic                 eligible;
    logic                 better;

    always_comb begin
        found    = 1'b0;
        index    = '0;
        best     = '0;
        eligible = 1'b0;
        better   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            eligible = valid[i] && ((mode == SelGlobalMin) || (versions[i] < bound));
            better   = (mode == SelBelowMax) ? (versions[i] > best) : (versions[i] < best);
            if (eligible && (!found || better)) begin
                found = 1'b1;
                index = IDX_W'(i);
                best  = versions[i];
            end
        end
    end

endmodule

// File: rtl/versioned_store.sv
// Multi-version store: write allocation with oldest-version eviction, flush, and
// registered "newest version below bound" reads with a valid/ready response.
module versioned_store
    import versioned_store_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int unsigned VERSION_W = DEFAULT_VERSION_W,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             wrValid,
    output logic                             wrReady,
    input  logic [VERSION_W-1:0]             wrVersion,
    input  logic [DATA_W-1:0]                wrData,
    input  logic                             flush,
    input  logic                             rdValid,
    output logic                             rdReady,
    input  logic [VERSION_W-1:0]             rdVersion,
    output logic                             rspValid,
    input  logic                             rspReady,
    output logic                             rspHit,
    output logic [VERSION_W-1:0]             rspVersion,
    output logic [DATA_W-1:0]                rspData,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy
);

    localparam int unsigned IDX_W = idx_width(NUM_SLOTS);
    localparam int unsigned OCCW  = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0]                slot_valid_q;
    logic [NUM_SLOTS-1:0][VERSION_W-1:0] slot_version_q;
    logic [NUM_SLOTS-1:0][DATA_W-1:0]    slot_data_q;
    logic [OCCW-1:0]                     occ_q;

    logic                 rsp_valid_q;
    logic                 rsp_hit_q;
    logic [VERSION_W-1:0] rsp_version_q;
    logic [DATA_W-1:0]    rsp_data_q;

    logic             wr_fire, rd_fire;
    logic             match_found, free_found, evict_found, rd_found;
    logic [IDX_W-1:0] match_idx, free_idx, evict_idx, rd_idx;
    logic             wr_en, occ_inc;
    logic [IDX_W-1:0] wr_idx;

    assign wrReady = !flush;
    assign rdReady = !rsp_valid_q || rspReady;
    assign wr_fire = wrValid && wrReady;
    assign rd_fire = rdValid && rdReady;

    version_select #(
        .NUM_SLOTS (NUM_SLOTS),
        .VERSION_W (VERSION_W)
    ) u_rd_select (
        .valid    (slot_valid_q),
        .versions (slot_version_q),
        .bound    (rdVersion),
        .mode     (SelBelowMax),
        .found    (rd_found),
        .index    (rd_idx)
    );

    version_select #(
        .NUM_SLOTS (NUM_SLOTS),
        .VERSION_W (VERSION_W)
    ) u_evict_select (
        .valid    (slot_valid_q),
        .versions (slot_version_q),
        .bound    ('0),
        .mode     (SelGlobalMin),
        .found    (evict_found),
        .index    (evict_idx)
    );

    // Descending scan so the lowest matching / free index is the one kept.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_valid_q[i] && (slot_version_q[i] == wrVersion)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!slot_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        occ_inc = 1'b0;
        if (wr_fire) begin
            if (match_found) begin
                wr_en  = 1'b1;
                wr_idx = match_idx;
            end else if (free_found) begin
                wr_en   = 1'b1;
                wr_idx  = free_idx;
                occ_inc = 1'b1;
            end else if (evict_found) begin
                wr_en  = 1'b1;
                wr_idx = evict_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            slot_valid_q   <= '0;
            slot_version_q <= '0;
            slot_data_q    <= '0;
            occ_q          <= '0;
        end else begin
            if (flush) begin
                slot_valid_q <= '0;
                occ_q        <= '0;
            end else if (wr_en) begin
                slot_valid_q[wr_idx]   <= 1'b1;
                slot_version_q[wr_idx] <= wrVersion;
                slot_data_q[wr_idx]    <= wrData;
                if (occ_inc) begin
                    occ_q <= occ_q + OCCW'(1);
                end
            end
        end
    end

    // Reads sample the pre-edge store, so a same-cycle write or flush is not seen.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_version_q <= '0;
            rsp_data_q    <= '0;
        end else if (rd_fire) begin
            rsp_valid_q   <= 1'b1;
            rsp_hit_q     <= rd_found;
            rsp_version_q <= rd_found ? slot_version_q[rd_idx] : '0;
            rsp_data_q    <= rd_found ? slot_data_q[rd_idx] : '0;
        end else if (rspReady) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rspValid   = rsp_valid_q;
    assign rspHit     = rsp_hit_q;
    assign rspVersion = rsp_version_q;
    assign rspData    = rsp_data_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_versioned_store.sv
// Directed and random checks of versioned_store against a slot-array reference model.
module tb_versioned_store;

    logic        clk = 1'b0;
    logic        rstN;
    logic        wrValid, flush, rdValid, rspReady;
    logic [3:0]  wrVersion, rdVersion;
    logic [31:0] wrData;
    logic        wrReady, rdReady, rspValid, rspHit;
    logic [3:0]  rspVersion;
    logic [31:0] rspData;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot contents and the expected response register.
    bit          m_valid[4];
    logic [3:0]  m_ver[4];
    logic [31:0] m_data[4];
    bit          e_valid;
    bit          e_hit;
    logic [3:0]  e_ver;
    logic [31:0] e_data;

    versioned_store dut (
        .clk        (clk),
        .rstN       (rstN),
        .wrValid    (wrValid),
        .wrReady    (wrReady),
        .wrVersion  (wrVersion),
        .wrData     (wrData),
        .flush      (flush),
        .rdValid    (rdValid),
        .rdReady    (rdReady),
        .rdVersion  (rdVersion),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspHit     (rspHit),
        .rspVersion (rspVersion),
        .rspData    (rspData),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        for (int s = 0; s < 4; s++) if (m_valid[s]) n++;
        return n;
    endfunction

    // Walk versions downward from the bound; the first one present is the newest below it.
    task automatic model_read(input logic [3:0] bound, output bit hit, output logic [3:0] ver,
                              output logic [31:0] data);
        hit  = 0;
        ver  = '0;
        data = '0;
        for (int v = int'(bound) - 1; v >= 0 && !hit; v--) begin
            for (int s = 0; s < 4; s++) begin
                if (!hit && m_valid[s] && m_ver[s] == 4'(v)) begin
                    hit  = 1;
                    ver  = m_ver[s];
                    data = m_data[s];
                end
            end
        end
    endtask

    task automatic model_write(input logic [3:0] v, input logic [31:0] d);
        int tgt = -1;
        for (int s = 0; s < 4; s++) if (m_valid[s] && m_ver[s] == v) tgt = s;
        for (int s = 0; s < 4; s++) if (tgt < 0 && !m_valid[s]) tgt = s;
        for (int x = 0; x < 16 && tgt < 0; x++)
            for (int s = 0; s < 4; s++) if (tgt < 0 && m_ver[s] == 4'(x)) tgt = s;
        m_valid[tgt] = 1;
        m_ver[tgt]   = v;
        m_data[tgt]  = d;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 0;
            m_ver[s]   = '0;
            m_data[s]  = '0;
        end
        e_valid = 0;
        e_hit   = 0;
        e_ver   = '0;
        e_data  = '0;
    endtask

    // One clock: predict from the pre-edge state, advance, then compare every output.
    task automatic do_cycle();
        bit          rd_fire, wr_fire, h;
        logic [3:0]  v;
        logic [31:0] d;
        rd_fire = rdValid && (!e_valid || rspReady);
        wr_fire = wrValid && !flush;
        if (rd_fire) model_read(rdVersion, h, v, d);
        @(posedge clk);
        #1;
        if (rd_fire) begin
            e_valid = 1;
            e_hit   = h;
            e_ver   = v;
            e_data  = d;
        end else if (rspReady) begin
            e_valid = 0;
        end
        if (flush) begin
            for (int s = 0; s < 4; s++) m_valid[s] = 0;
        end else if (wr_fire) begin
            model_write(wrVersion, wrData);
        end
        check("rspValid", 64'(rspValid), 64'(e_valid));
        if (e_valid) begin
            check("rspHit", 64'(rspHit), 64'(e_hit));
            check("rspVersion", 64'(rspVersion), 64'(e_ver));
            check("rspData", 64'(rspData), 64'(e_data));
        end
        check("occupancy", 64'(occupancy), 64'(model_occ()));
        check("rdReady", 64'(rdReady), 64'(!e_valid || rspReady));
        check("wrReady", 64'(wrReady), 64'(!flush));
    endtask

    task automatic wr(input logic [3:0] v, input logic [31:0] d);
        wrValid   = 1;
        wrVersion = v;
        wrData    = d;
        do_cycle();
        wrValid = 0;
    endtask

    task automatic rd(input logic [3:0] v);
        rdValid   = 1;
        rdVersion = v;
        do_cycle();
        rdValid = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        do_cycle();
        flush = 0;
    endtask

    initial begin
        rstN      = 0;
        wrValid   = 0;
        flush     = 0;
        rdValid   = 0;
        rspReady  = 1;
        wrVersion = '0;
        rdVersion = '0;
        wrData    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rspValid", 64'(rspValid), 64'(0));
        check("reset_occupancy", 64'(occupancy), 64'(0));
        check("reset_rdReady", 64'(rdReady), 64'(1));
        check("reset_wrReady", 64'(wrReady), 64'(1));
        @(negedge clk);
        rstN = 1;
        @(posedge clk);
        #1;

        // Empty store misses.
        rd(4'd5);
        check("empty_hit", 64'(rspHit), 64'(0));
        check("empty_data", 64'(rspData), 64'(0));
        check("empty_occ", 64'(occupancy), 64'(0));

        wr(4'd2, 32'hA);
        wr(4'd7, 32'hB);
        wr(4'd4, 32'hC);
        rd(4'd5);
        check("rd5_hit", 64'(rspHit), 64'(1));
        check("rd5_ver", 64'(rspVersion), 64'(4));
        check("rd5_data", 64'(rspData), 64'hC);
        rd(4'd8);
        check("rd8_ver", 64'(rspVersion), 64'(7));
        check("rd8_data", 64'(rspData), 64'hB);
        rd(4'd2);
        check("rd2_hit", 64'(rspHit), 64'(0));
        check("rd2_ver", 64'(rspVersion), 64'(0));

        // Eviction of the smallest version when full.
        do_flush();
        wr(4'd1, 32'h11);
        wr(4'd3, 32'h33);
        wr(4'd5, 32'h55);
        wr(4'd9, 32'h99);
        check("full_occ", 64'(occupancy), 64'(4));
        wr(4'd6, 32'hD);
        check("evict_occ", 64'(occupancy), 64'(4));
        rd(4'd2);
        check("evict_rd2_hit", 64'(rspHit), 64'(0));
        rd(4'd7);
        check("evict_rd7_ver", 64'(rspVersion), 64'(6));
        check("evict_rd7_data", 64'(rspData), 64'hD);

        // Same-version write overwrites in place.
        do_flush();
        wr(4'd3, 32'h1);
        wr(4'd3, 32'h2);
        check("dup_occ", 64'(occupancy), 64'(1));
        rd(4'd4);
        check("dup_data", 64'(rspData), 64'h2);

        // Backpressure: the held response stays put and new reads are refused.
        rspReady = 0;
        rd(4'd4);
        rdValid   = 1;
        rdVersion = 4'd15;
        wrValid   = 1;
        wrVersion = 4'd8;
        wrData    = 32'h77;
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            wrValid = 0;
            check("stall_rdReady", 64'(rdReady), 64'(0));
            check("stall_hit", 64'(rspHit), 64'(1));
            check("stall_ver", 64'(rspVersion), 64'(3));
            check("stall_data", 64'(rspData), 64'h2);
        end
        rspReady = 1;
        do_cycle();
        rdValid = 0;
        check("release_ver", 64'(rspVersion), 64'(8));
        check("release_data", 64'(rspData), 64'h77);

        // Flush, write and read in one cycle.
        do_flush();
        wr(4'd2, 32'h55);
        flush     = 1;
        wrValid   = 1;
        wrVersion = 4'd9;
        wrData    = 32'hEE;
        rdValid   = 1;
        rdVersion = 4'd3;
        #1;
        check("flush_wrReady", 64'(wrReady), 64'(0));
        do_cycle();
        flush   = 0;
        wrValid = 0;
        rdValid = 0;
        check("flush_rd_hit", 64'(rspHit), 64'(1));
        check("flush_rd_ver", 64'(rspVersion), 64'(2));
        check("flush_rd_data", 64'(rspData), 64'h55);
        check("flush_occ", 64'(occupancy), 64'(0));

        // Asynchronous reset while a response is pending.
        wr(4'd2, 32'h99);
        rspReady = 0;
        rd(4'd5);
        check("pre_reset_valid", 64'(rspValid), 64'(1));
        #2;
        rstN = 0;
        #1;
        check("async_rst_valid", 64'(rspValid), 64'(0));
        check("async_rst_occ", 64'(occupancy), 64'(0));
        model_clear();
        @(negedge clk);
        rstN     = 1;
        rspReady = 1;
        @(posedge clk);
        #1;
        rd(4'd5);
        check("post_reset_hit", 64'(rspHit), 64'(0));

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            wrValid   = ($urandom_range(0, 1) == 1);
            wrVersion = 4'($urandom_range(0, 15));
            wrData    = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            rdValid   = ($urandom_range(0, 9) < 6);
            rdVersion = 4'($urandom_range(0, 15));
            rspReady  = ($urandom_range(0, 9) < 7);
            do_cycle();
        end
        wrValid = 0;
        flush   = 0;
        rdValid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
